// File: rtl/disp_bcd_scan.sv
// Binary-to-BCD (sequential double-dabble) and 6-digit multiplexed 7-seg scan.
// Optional DISP_DP_EN adds dp_pos input for decimal point and blanking floor.
module disp_bcd_scan #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] disp_data,
  input  logic        disp_en,
`ifdef DISP_DP_EN
  input  logic [2:0]  dp_pos,
`endif
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        busy
);

  localparam int DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(DIV - 1);
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [23:0] MAX_VAL = 24'd999_999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] shreg_q, shreg_d;
  logic [23:0] work_q, work_d;
  logic [23:0] bcd_q, bcd_d;
  logic [23:0] last_q, last_d;
  logic        busy_q, busy_d;
  logic [CW-1:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;

  logic [23:0] adj;
  logic [2:0]  msd;
  logic [2:0]  lim;
  logic [3:0]  digit;
  logic [7:0]  code;

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] c;
    unique case (d)
      4'd0: c = 8'h3F;
      4'd1: c = 8'h06;
      4'd2: c = 8'h5B;
      4'd3: c = 8'h4F;
      4'd4: c = 8'h66;
      4'd5: c = 8'h6D;
      4'd6: c = 8'h7D;
      4'd7: c = 8'h07;
      4'd8: c = 8'h7F;
      4'd9: c = 8'h6F;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // add-3 correction on each work nibble before the shift
  always_comb begin
    adj = '0;
    for (int i = 0; i < 6; i++) begin
      if (work_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = work_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    last_d  = last_q;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (disp_data != last_q) begin
          last_d  = disp_data;
          shreg_d = (disp_data > MAX_VAL) ? MAX_VAL : disp_data;
          work_d  = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d  = {adj[22:0], shreg_q[23]};
        shreg_d = {shreg_q[22:0], 1'b0};
        bit_d   = bit_q + 5'd1;
        if (bit_q == 5'd23)
          state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = work_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q + CW'(1);
    idx_d = idx_q;
    if (div_q == DIV_MAX) begin
      div_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // lim: highest digit index that must stay visible
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0)
        msd = 3'(i);
    end
    lim = msd;
`ifdef DISP_DP_EN
    if (dp_pos < 3'd6 && dp_pos > lim)
      lim = dp_pos;
`endif
    digit = bcd_q[{idx_q, 2'b00} +: 4];
    code  = enc(digit);
`ifdef DISP_DP_EN
    if (idx_q == dp_pos)
      code[7] = 1'b1;
`endif
    if (idx_q > lim)
      code = 8'h00;
    sel_d = 6'b1 << idx_q;
    seg_d = SEG_ACTIVE_LOW ? ~code : code;
    if (!disp_en) begin
      sel_d = '0;
      seg_d = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      shreg_q <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign sel  = sel_q;
  assign seg  = seg_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_disp_bcd_scan.sv
// Bench for disp_bcd_scan: value-level timeline model checked every cycle,
// plus literal digit/timing expectations.
module tb_disp_bcd_scan;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] disp_data = '0;
  logic        disp_en = 1'b1;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  disp_bcd_scan #(
    .CLK_FREQ_HZ(1000),
    .SCAN_HZ(100),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .disp_data(disp_data),
    .disp_en(disp_en),
    .sel(sel),
    .seg(seg),
    .busy(busy)
  );

  logic [7:0] hi_code [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  function automatic int pow10(input int i);
    int p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] digit_seg(input int v, input int i);
    int d;
    if (i > 0 && v < pow10(i)) return 8'hFF;
    d = (v / pow10(i)) % 10;
    return ~hi_code[d];
  endfunction

  // model: shown value changes 25 clocks after capture; index from clock count
  int k, m_idx, m_last, m_val, m_shown, m_rem;
  bit m_conv, m_valid = 1'b0;
  logic [5:0] e_sel;
  logic [7:0] e_seg;
  logic       e_busy;

  always @(posedge clk) begin
    if (reset) begin
      e_sel = '0; e_seg = 8'hFF; e_busy = 1'b0;
      k = 0; m_last = 0; m_shown = 0; m_conv = 0; m_rem = 0;
      m_valid = 1'b1;
    end else begin
      m_idx = (k / DIV) % 6;
      if (disp_en) begin
        e_sel = 6'(1 << m_idx);
        e_seg = digit_seg(m_shown, m_idx);
      end else begin
        e_sel = '0;
        e_seg = 8'hFF;
      end
      if (m_conv) begin
        m_rem--;
        if (m_rem == 0) begin
          m_conv = 0; e_busy = 1'b0; m_shown = m_val;
        end
      end else if (int'(disp_data) != m_last) begin
        m_conv = 1; m_rem = 25; m_last = int'(disp_data);
        m_val = (m_last > 999999) ? 999999 : m_last;
        e_busy = 1'b1;
      end
      k++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (m_valid) begin
      chk("model_sel", 32'(sel), 32'(e_sel));
      chk("model_seg", 32'(seg), 32'(e_seg));
      chk("model_busy", 32'(busy), 32'(e_busy));
    end
  endtask

  task automatic wait_busy(input logic v, input int limit);
    int n = 0;
    while (busy !== v && n < limit) begin
      tick();
      n++;
    end
    chk("wait_busy", 32'(busy), 32'(v));
  endtask

  task automatic check_digit(input int i, input logic [7:0] exp);
    int n = 0;
    tick();
    while (sel !== 6'(1 << i) && n < 80) begin
      tick();
      n++;
    end
    chk("digit_sel", 32'(sel), 32'(1 << i));
    chk($sformatf("digit%0d_seg", i), 32'(seg), 32'(exp));
  endtask

  function automatic int sel_idx(input logic [5:0] s);
    int r = -1;
    for (int i = 0; i < 6; i++) if (s[i]) r = i;
    return r;
  endfunction

  initial begin
    int cnt, b, a;
    repeat (3) tick();
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    check_digit(0, 8'hC0);
    check_digit(1, 8'hFF);
    check_digit(5, 8'hFF);

    disp_data = 24'd300;
    wait_busy(1'b1, 5);
    cnt = 1;
    for (int j = 0; j < 60; j++) begin
      tick();
      if (busy !== 1'b1) break;
      cnt++;
    end
    chk("busy_len", 32'(cnt), 32'd25);
    repeat (2) tick();
    check_digit(0, 8'hC0);
    check_digit(1, 8'hC0);
    check_digit(2, 8'hB0);
    check_digit(3, 8'hFF);
    check_digit(5, 8'hFF);

    disp_data = 24'd16_777_215;
    wait_busy(1'b1, 5);
    wait_busy(1'b0, 40);
    repeat (2) tick();
    for (int i = 0; i < 6; i++) check_digit(i, 8'h90);

    disp_data = 24'd10;
    wait_busy(1'b1, 5);
    repeat (5) tick();
    disp_data = 24'd20;
    wait_busy(1'b0, 40);
    cnt = 1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (busy === 1'b1) break;
      cnt++;
    end
    chk("busy_gap", 32'(cnt), 32'd1);
    wait_busy(1'b0, 40);
    repeat (2) tick();
    check_digit(0, 8'hC0);
    check_digit(1, 8'hA4);
    check_digit(2, 8'hFF);

    b = sel_idx(sel);
    disp_en = 1'b0;
    tick();
    chk("dis_sel", 32'(sel), 32'h0);
    chk("dis_seg", 32'(seg), 32'hFF);
    repeat (34) tick();
    disp_en = 1'b1;
    tick();
    a = sel_idx(sel);
    chk("reen_adv", 32'(a == (b + 3) % 6 || a == (b + 4) % 6), 32'd1);
    repeat (20) tick();

    disp_data = 24'd555;
    wait_busy(1'b1, 5);
    repeat (12) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_sel", 32'(sel), 32'h0);
    tick();
    chk("restart_busy", 32'(busy), 32'h1);
    check_digit(0, 8'hC0);
    wait_busy(1'b0, 40);
    repeat (2) tick();
    check_digit(0, 8'h92);
    check_digit(2, 8'h92);
    check_digit(3, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
